gate_sweep_ctrl: RTL and testbench
==================================

# gate_sweep_ctrl

Self-checking sweep controller for small combinational gates such as the three-input AND. On `start` it walks every input vector 0 … 2^N_IN−1 onto the gate under test. After a programmable settle time it samples the gate output, records it into a captured truth table and compares it against an expected truth table. It then reports pass/fail, a mismatch count and the first failing vector. It sits between a board-level start button or host register and the gate datapath, and replaces hand-written exhaustive stimulus loops.

## Interface
Parameters:
- `N_IN`, 3, number of gate inputs; sweep length is 2^N_IN vectors.
- `SETTLE`, 2, settle cycles per vector before sampling; 0 is legal.
- `EXPECT_TT`, 8'h80, expected truth table; bit k is the required output for input vector k. Width 2^N_IN. The default is 3-input AND.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a sweep; honoured only in IDLE.
- `abort` in 1: terminate a sweep in progress.
- `stim` out N_IN: vector driven to the gate; bit 0 → A, bit 1 → B, bit 2 → C.
- `dut_y` in 1: gate output.
- `busy` out 1: high from the cycle after start acceptance until DONE is left.
- `done` out 1: one-cycle pulse when a sweep completes (not on abort).
- `pass` out 1: `err_count == 0`; valid from `done`, held until next start.
- `err_count` out N_IN+1: number of mismatching vectors.
- `first_fail` out N_IN: lowest mismatching vector index.
- `first_fail_vld` out 1: at least one mismatch recorded.
- `captured_tt` out 2^N_IN: sampled output per vector.

## Operation
- **Reset values:** all outputs 0 (`stim`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail`=0, `first_fail_vld`=0, `captured_tt`=0); state IDLE. Reset mid-sweep aborts immediately with the same values.
- **FSM states:** IDLE, SETTLE, SAMPLE, DONE.
- **IDLE:**
  - `start`=1 and `abort`=0: clear all result registers, set `stim`←0 and settle counter←0, then go to SETTLE. If `SETTLE`=0, go directly to SAMPLE.
  - `start`=1 and `abort`=1: abort wins; remain in IDLE.
- **SETTLE:** hold `stim`; increment the counter; after `SETTLE` cycles go to SAMPLE.
- **SAMPLE:**
  - Set `captured_tt[stim]`←`dut_y`.
  - If `dut_y` ≠ `EXPECT_TT[stim]`: increment `err_count`. If `first_fail_vld`=0, also set `first_fail`←`stim` and `first_fail_vld`←1.
  - If `stim` = 2^N_IN−1, go to DONE. Otherwise set `stim`←`stim`+1, clear the counter, and go to SETTLE (or SAMPLE again when `SETTLE`=0).
- **DONE:** `done`=1 for this cycle only. `pass` is registered from the final `err_count`. Return to IDLE next cycle. `stim` holds its last value; results hold until the next accepted start.
- **`abort`** in SETTLE, SAMPLE or DONE: go to IDLE next cycle, `stim`←0, `busy`←0, no `done`. Partial results stay visible and `pass` stays 0.
- **`start`** while busy: ignored.
- **Width rules:**
  - `err_count` is N_IN+1 bits, so a maximum of 2^N_IN cannot overflow.
  - The vector counter compares against 2^N_IN−1 explicitly and never wraps.

## Timing
- Start accepted at edge t0; `stim`=0 and `busy`=1 from t0+1.
- Each vector occupies `SETTLE`+1 cycles. Vector k is sampled at edge t0+(k+1)(`SETTLE`+1).
- `done` pulses at t0 + 2^N_IN·(`SETTLE`+1) + 1. With the defaults this is t0+25; with `SETTLE`=0 it is t0+9.
- `busy` falls in the cycle after `done`. A new `start` is accepted from that cycle onward.
- `dut_y` is treated as combinational from `stim`. `SETTLE` must cover the gate delay plus any I/O registering.

## Structure
- Package `gate_sweep_pkg`: state enum (IDLE/SETTLE/SAMPLE/DONE), and a function `tt_width(n)` = 2^n.
- One sub-module, `settle_timer`: loadable down-counter with `SETTLE` parameter, `clr` input and `expired` output. All other logic stays in a single FSM process.

## Test plan
- Correct 3-input AND attached, defaults → `done` at t0+25, `pass`=1, `err_count`=0, `captured_tt`=8'h80, `first_fail_vld`=0.
- `dut_y` stuck at 0 → `err_count`=1, `first_fail`=7, `captured_tt`=8'h00, `pass`=0.
- `dut_y` stuck at 1 → `err_count`=7, `first_fail`=0, `captured_tt`=8'hFF.
- `start` re-pulsed at t0+10 → ignored, `done` still at t0+25. Then `abort` during vector 4 of a second sweep → idle next cycle, `stim`=0, no `done`.
- `rst` asserted at t0+12 → next cycle all outputs 0. Follow-up start gives a clean full sweep.
- `SETTLE`=0 with AND gate → `stim` increments every cycle, `done` at t0+9, `pass`=1.

Source files
------------

// File: rtl/gate_sweep_pkg.sv
// Shared types and helpers for the gate sweep controller.
package gate_sweep_pkg;

   // Sweep controller states.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   // Number of rows in the truth table of an n-input gate.
   function automatic int tt_width(input int n);
      return 1 << n;
   endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that times the settle window for each vector.
// clr loads SETTLE; while en is high the count walks down to 1, and
// expired marks the last settle cycle so the FSM can move to SAMPLE
// on the following edge. Unused (never expires) when SETTLE is 0.
module settle_timer #(
   parameter int SETTLE = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
   localparam logic [W-1:0] LOAD = W'(SETTLE);
   localparam logic [W-1:0] ONE  = W'(1);

   logic [W-1:0] cnt_q, cnt_d;

   // Next count: load on clr, otherwise decrement while enabled, floor at 0.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = LOAD;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - ONE;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == ONE);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive sweep controller for a small combinational gate.
// Walks every input vector, waits SETTLE cycles, samples dut_y, builds
// the captured truth table and compares it with EXPECT_TT.
// start/abort are level inputs sampled on the rising edge: start is only
// honoured in IDLE, abort wins over start and terminates any sweep stage.
module gate_sweep_ctrl
   import gate_sweep_pkg::*;
#(
   parameter int                           N_IN      = 3,
   parameter int                           SETTLE    = 2,
   parameter logic [tt_width(N_IN)-1:0]    EXPECT_TT = 8'h80
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        abort,
   output logic [N_IN-1:0]             stim,
   input  logic                        dut_y,
   output logic                        busy,
   output logic                        done,
   output logic                        pass,
   output logic [N_IN:0]               err_count,
   output logic [N_IN-1:0]             first_fail,
   output logic                        first_fail_vld,
   output logic [tt_width(N_IN)-1:0]   captured_tt,
   output state_t                      dbg_state_o
);

   localparam int                NV       = tt_width(N_IN);
   localparam logic [N_IN-1:0]   LAST_VEC = N_IN'(NV - 1);
   localparam logic [N_IN-1:0]   VEC_ONE  = N_IN'(1);
   localparam logic [N_IN:0]     ERR_ONE  = (N_IN + 1)'(1);
   // With no settle time every vector goes straight to SAMPLE.
   localparam state_t            VEC_ENTRY = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

   state_t            state_q, state_d;
   logic [N_IN-1:0]   stim_q, stim_d;
   logic              busy_q, busy_d;
   logic              pass_q, pass_d;
   logic [N_IN:0]     err_q, err_d;
   logic [N_IN-1:0]   ff_q, ff_d;
   logic              ffv_q, ffv_d;
   logic [NV-1:0]     cap_q, cap_d;

   logic              tmr_clr;
   logic              tmr_en;
   logic              tmr_expired;

   settle_timer #(
      .SETTLE (SETTLE)
   ) u_settle_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .expired (tmr_expired)
   );

   // Next-state and result update logic for the sweep FSM.
   always_comb begin
      state_d = state_q;
      stim_d  = stim_q;
      busy_d  = busy_q;
      pass_d  = pass_q;
      err_d   = err_q;
      ff_d    = ff_q;
      ffv_d   = ffv_q;
      cap_d   = cap_q;
      tmr_clr = 1'b0;
      tmr_en  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               cap_d   = '0;
               err_d   = '0;
               ff_d    = '0;
               ffv_d   = 1'b0;
               pass_d  = 1'b0;
               stim_d  = '0;
               busy_d  = 1'b1;
               tmr_clr = 1'b1;
               state_d = VEC_ENTRY;
            end
         end

         S_SETTLE: begin
            if (abort) begin
               stim_d  = '0;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               tmr_en = 1'b1;
               if (tmr_expired) begin
                  state_d = S_SAMPLE;
               end
            end
         end

         S_SAMPLE: begin
            if (abort) begin
               stim_d  = '0;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               cap_d[stim_q] = dut_y;
               if (dut_y != EXPECT_TT[stim_q]) begin
                  err_d = err_q + ERR_ONE;
                  if (!ffv_q) begin
                     ff_d  = stim_q;
                     ffv_d = 1'b1;
                  end
               end
               // Explicit end-of-sweep compare so the vector never wraps.
               if (stim_q == LAST_VEC) begin
                  pass_d  = (err_d == '0);
                  state_d = S_DONE;
               end else begin
                  stim_d  = stim_q + VEC_ONE;
                  tmr_clr = 1'b1;
                  state_d = VEC_ENTRY;
               end
            end
         end

         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
            if (abort) begin
               stim_d = '0;
               pass_d = 1'b0;
            end
         end

         default: begin
            stim_d  = '0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         stim_q  <= '0;
         busy_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         ff_q    <= '0;
         ffv_q   <= 1'b0;
         cap_q   <= '0;
      end else begin
         state_q <= state_d;
         stim_q  <= stim_d;
         busy_q  <= busy_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         ff_q    <= ff_d;
         ffv_q   <= ffv_d;
         cap_q   <= cap_d;
      end
   end

   // done is the DONE-state cycle, suppressed if abort arrives in it.
   assign done           = (state_q == S_DONE) && !abort;
   assign stim           = stim_q;
   assign busy           = busy_q;
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign first_fail     = ff_q;
   assign first_fail_vld = ffv_q;
   assign captured_tt    = cap_q;
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: a default-settle instance (a) with a
// selectable gate model and a SETTLE=0 instance (b) with a correct AND.
// Outputs are sampled on the falling edge; the n-th falling edge after the
// start-accepting edge t0 ends the cycle whose values are seen at edge t0+n.
module tb_gate_sweep_ctrl;
  import gate_sweep_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_a, abort_a, start_b, abort_b;
  logic [2:0] stim_a, stim_b;
  logic y_a, y_b;
  logic busy_a, done_a, pass_a, ffv_a;
  logic busy_b, done_b, pass_b, ffv_b;
  logic [3:0] err_a, err_b;
  logic [2:0] ff_a, ff_b;
  logic [7:0] cap_a, cap_b;
  state_t st_a, st_b;

  int mode;  // 0: AND gate, 1: stuck at 0, 2: stuck at 1
  int checks = 0;
  int fails = 0;
  int n = 0;

  assign y_a = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : (stim_a[0] & stim_a[1] & stim_a[2]);
  assign y_b = stim_b[0] & stim_b[1] & stim_b[2];

  gate_sweep_ctrl u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .stim(stim_a),
    .dut_y(y_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_fail(ff_a), .first_fail_vld(ffv_a),
    .captured_tt(cap_a), .dbg_state_o(st_a)
  );

  gate_sweep_ctrl #(.N_IN(3), .SETTLE(0), .EXPECT_TT(8'h80)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .stim(stim_b),
    .dut_y(y_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_fail(ff_b), .first_fail_vld(ffv_b),
    .captured_tt(cap_b), .dbg_state_o(st_b)
  );

  // Hard time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
    n++;
  endtask

  task automatic do_start_a();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n = 1;
  endtask

  task automatic do_start_b();
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n = 1;
  endtask

  // Full sweep on instance a, recording when done is seen and how often.
  task automatic run_a(output int done_at, output int dcount);
    do_start_a();
    done_at = -1;
    dcount = 0;
    while (n < 40) begin
      if (done_a === 1'b1) begin
        dcount++;
        if (done_at < 0) done_at = n;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (stim_a !== 3'd0) begin fails++; $display("FAIL reset_stim: got %0h expected 0", stim_a); end
    checks++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin fails++; $display("FAIL reset_done: got %0b expected 0", done_a); end
    checks++; if (pass_a !== 1'b0) begin fails++; $display("FAIL reset_pass: got %0b expected 0", pass_a); end
    checks++; if (err_a !== 4'd0) begin fails++; $display("FAIL reset_err: got %0h expected 0", err_a); end
    checks++; if (ff_a !== 3'd0 || ffv_a !== 1'b0) begin fails++; $display("FAIL reset_ff: got %0h/%0b expected 0/0", ff_a, ffv_a); end
    checks++; if (cap_a !== 8'h00) begin fails++; $display("FAIL reset_cap: got %0h expected 00", cap_a); end
    checks++; if (st_a !== S_IDLE) begin fails++; $display("FAIL reset_state: got %0d expected %0d", st_a, S_IDLE); end
    checks++; if (busy_b !== 1'b0 || stim_b !== 3'd0) begin fails++; $display("FAIL reset_b: got busy %0b stim %0h expected 0 0", busy_b, stim_b); end
    rst = 1'b0;
  endtask

  task automatic test_and_sweep();
    int done_at;
    int dcount;
    mode = 0;
    do_start_a();
    done_at = -1;
    dcount = 0;
    while (n < 40) begin
      if (n == 1) begin
        checks++; if (busy_a !== 1'b1 || stim_a !== 3'd0) begin fails++; $display("FAIL and_first_cycle: got busy %0b stim %0h expected 1 0", busy_a, stim_a); end
      end
      if (n == 13) begin
        checks++; if (stim_a !== 3'd4) begin fails++; $display("FAIL and_stim_walk: got %0h expected 4", stim_a); end
      end
      if (n == 26) begin
        checks++; if (busy_a !== 1'b0) begin fails++; $display("FAIL and_busy_fall: got %0b expected 0", busy_a); end
      end
      if (done_a === 1'b1) begin
        dcount++;
        if (done_at < 0) done_at = n;
        checks++; if (pass_a !== 1'b1) begin fails++; $display("FAIL and_pass_at_done: got %0b expected 1", pass_a); end
      end
      tick();
    end
    checks++; if (done_at != 25 || dcount != 1) begin fails++; $display("FAIL and_done_time: got t0+%0d x%0d expected t0+25 x1", done_at, dcount); end
    checks++; if (err_a !== 4'd0) begin fails++; $display("FAIL and_err: got %0h expected 0", err_a); end
    checks++; if (cap_a !== 8'h80) begin fails++; $display("FAIL and_cap: got %0h expected 80", cap_a); end
    checks++; if (ffv_a !== 1'b0) begin fails++; $display("FAIL and_ffv: got %0b expected 0", ffv_a); end
    checks++; if (pass_a !== 1'b1) begin fails++; $display("FAIL and_pass_held: got %0b expected 1", pass_a); end
    checks++; if (stim_a !== 3'd7) begin fails++; $display("FAIL and_stim_hold: got %0h expected 7", stim_a); end
  endtask

  task automatic test_stuck0();
    int done_at;
    int dcount;
    mode = 1;
    run_a(done_at, dcount);
    checks++; if (done_at != 25) begin fails++; $display("FAIL s0_done_time: got t0+%0d expected t0+25", done_at); end
    checks++; if (err_a !== 4'd1) begin fails++; $display("FAIL s0_err: got %0h expected 1", err_a); end
    checks++; if (ff_a !== 3'd7 || ffv_a !== 1'b1) begin fails++; $display("FAIL s0_first_fail: got %0h/%0b expected 7/1", ff_a, ffv_a); end
    checks++; if (cap_a !== 8'h00) begin fails++; $display("FAIL s0_cap: got %0h expected 00", cap_a); end
    checks++; if (pass_a !== 1'b0) begin fails++; $display("FAIL s0_pass: got %0b expected 0", pass_a); end
  endtask

  task automatic test_stuck1();
    int done_at;
    int dcount;
    mode = 2;
    run_a(done_at, dcount);
    checks++; if (err_a !== 4'd7) begin fails++; $display("FAIL s1_err: got %0h expected 7", err_a); end
    checks++; if (ff_a !== 3'd0 || ffv_a !== 1'b1) begin fails++; $display("FAIL s1_first_fail: got %0h/%0b expected 0/1", ff_a, ffv_a); end
    checks++; if (cap_a !== 8'hFF) begin fails++; $display("FAIL s1_cap: got %0h expected ff", cap_a); end
    checks++; if (pass_a !== 1'b0) begin fails++; $display("FAIL s1_pass: got %0b expected 0", pass_a); end
  endtask

  task automatic test_back_to_back();
    int done_at;
    int dcount;
    mode = 0;
    do_start_a();
    done_at = -1;
    dcount = 0;
    while (n < 40) begin
      if (done_a === 1'b1) begin
        dcount++;
        if (done_at < 0) done_at = n;
      end
      start_a = (n == 10);
      tick();
    end
    start_a = 1'b0;
    checks++; if (done_at != 25 || dcount != 1) begin fails++; $display("FAIL restart_ignored: got t0+%0d x%0d expected t0+25 x1", done_at, dcount); end
    checks++; if (pass_a !== 1'b1) begin fails++; $display("FAIL restart_pass: got %0b expected 1", pass_a); end

    do_start_a();
    while (n < 13) tick();
    checks++; if (stim_a !== 3'd4) begin fails++; $display("FAIL abort_pre_stim: got %0h expected 4", stim_a); end
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    checks++; if (busy_a !== 1'b0 || stim_a !== 3'd0) begin fails++; $display("FAIL abort_idle: got busy %0b stim %0h expected 0 0", busy_a, stim_a); end
    checks++; if (st_a !== S_IDLE) begin fails++; $display("FAIL abort_state: got %0d expected %0d", st_a, S_IDLE); end
    dcount = 0;
    repeat (30) begin
      if (done_a === 1'b1) dcount++;
      tick();
    end
    checks++; if (dcount != 0) begin fails++; $display("FAIL abort_no_done: got %0d pulses expected 0", dcount); end
    checks++; if (pass_a !== 1'b0 || err_a !== 4'd0 || cap_a !== 8'h00) begin fails++; $display("FAIL abort_partial: got pass %0b err %0h cap %0h expected 0 0 00", pass_a, err_a, cap_a); end
  endtask

  task automatic test_reset_mid();
    int done_at;
    int dcount;
    mode = 2;
    do_start_a();
    while (n < 11) tick();
    checks++; if (err_a !== 4'd3) begin fails++; $display("FAIL rstmid_partial_err: got %0h expected 3", err_a); end
    rst = 1'b1;
    tick();
    checks++; if (busy_a !== 1'b0 || stim_a !== 3'd0 || done_a !== 1'b0 || pass_a !== 1'b0) begin fails++; $display("FAIL rstmid_ctrl: got busy %0b stim %0h done %0b pass %0b expected all 0", busy_a, stim_a, done_a, pass_a); end
    checks++; if (err_a !== 4'd0 || ff_a !== 3'd0 || ffv_a !== 1'b0 || cap_a !== 8'h00) begin fails++; $display("FAIL rstmid_results: got err %0h ff %0h ffv %0b cap %0h expected all 0", err_a, ff_a, ffv_a, cap_a); end
    rst = 1'b0;
    mode = 0;
    run_a(done_at, dcount);
    checks++; if (done_at != 25 || pass_a !== 1'b1 || cap_a !== 8'h80 || err_a !== 4'd0) begin fails++; $display("FAIL rstmid_resweep: got done t0+%0d pass %0b cap %0h err %0h expected 25 1 80 0", done_at, pass_a, cap_a, err_a); end
  endtask

  task automatic test_settle0();
    int done_at;
    int dcount;
    int stim_bad;
    do_start_b();
    done_at = -1;
    dcount = 0;
    stim_bad = 0;
    while (n < 20) begin
      if (n >= 1 && n <= 8 && stim_b !== 3'(n - 1)) stim_bad++;
      if (done_b === 1'b1) begin
        dcount++;
        if (done_at < 0) done_at = n;
      end
      tick();
    end
    checks++; if (stim_bad != 0) begin fails++; $display("FAIL s0set_stim_step: got %0d bad cycles expected 0", stim_bad); end
    checks++; if (done_at != 9 || dcount != 1) begin fails++; $display("FAIL s0set_done_time: got t0+%0d x%0d expected t0+9 x1", done_at, dcount); end
    checks++; if (pass_b !== 1'b1 || cap_b !== 8'h80 || err_b !== 4'd0) begin fails++; $display("FAIL s0set_result: got pass %0b cap %0h err %0h expected 1 80 0", pass_b, cap_b, err_b); end
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0;
    abort_a = 1'b0;
    start_b = 1'b0;
    abort_b = 1'b0;
    mode = 0;
    test_reset();
    test_and_sweep();
    test_stuck0();
    test_stuck1();
    test_back_to_back();
    test_reset_mid();
    test_settle0();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
